// File: rtl/pipes_scroller_pkg.sv
// Shared pipe_t header for the pipes game: the list item layout, game constants and FSM encoding.
package pipes_scroller_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic signed [10:0] x;
        logic [8:0]         gap_y;
    } pipe_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FIRST,
        S_ITER,
        S_SPAWN
    } state_t;

    // Widen an 11-bit screen x into the 12-bit working domain.
    function automatic logic signed [11:0] sext_x(input logic signed [10:0] x);
        return {x[10], x};
    endfunction

endpackage

// File: rtl/pipes_scroller_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 15,13,12,10, shift left) used to randomise pipe gap heights.
module lfsr16
    import pipes_scroller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (step) begin
            value_d = {value_q[14:0], value_q[15] ^ value_q[13] ^ value_q[12] ^ value_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= LFSR_SEED;
        end else if (ce) begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipes_scroller.sv
// Per-frame pipe scroller: walks the pipe list, moves every pipe left, drops off-screen pipes, spawns new ones.
// Define PIPES_SCROLLER_SCORE_EN to compile in the score_pulse logic; otherwise score_pulse is tied low.
module pipes_scroller
    import pipes_scroller_pkg::*;
#(
    parameter int SCREEN_WIDTH = 640,
    parameter int PIPE_WIDTH   = 64,
    parameter int SPEED        = 2,
    parameter int SPAWN_DIST   = 200,
    parameter int GAP_MIN      = 96,
    parameter int BIRD_X       = 160
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  ce,
    input  logic  frame_tick,
    output logic  iter_start,
    input  logic  iter_done,
    input  pipe_t iter_out,
    output pipe_t iter_in,
    output logic  iter_remove,
    output logic  insert_en,
    output pipe_t insert_data,
    output logic  busy,
    output logic  overrun,
    output logic  score_pulse
);

    localparam logic signed [11:0] SPEED_S      = 12'(SPEED);
    localparam logic signed [11:0] PIPE_W_S     = 12'(PIPE_WIDTH);
    localparam logic signed [11:0] SPAWN_DIST_S = 12'(SPAWN_DIST);
    localparam logic [10:0]        SPAWN_X      = 11'(SCREEN_WIDTH);
    localparam logic [8:0]         GAP_MIN_9    = 9'(GAP_MIN);

    state_t             state_q, state_d;
    logic signed [11:0] spawn_cnt_q, spawn_cnt_d, spawn_next;
    logic               overrun_q, overrun_d;
    logic               iter_start_q, iter_start_d;
    logic               insert_en_q, insert_en_d;
    logic               busy_q, busy_d;
    pipe_t              insert_data_q, insert_data_d;
    logic               lfsr_step;
    logic [15:0]        lfsr_value;
    logic               unused_lfsr_hi;

    logic               in_pass;
    logic signed [11:0] x_old, x_new;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    assign unused_lfsr_hi = ^lfsr_value[15:8];

    // Item update is combinational: the list samples iter_in/iter_remove in the cycle it presents iter_out.
    assign in_pass = ce && (state_q == S_FIRST || state_q == S_ITER) && !iter_done;
    assign x_old   = sext_x(iter_out.x);
    assign x_new   = x_old - SPEED_S;

    always_comb begin
        iter_in   = iter_out;
        iter_in.x = x_new[10:0];
    end

    assign iter_remove = in_pass && (x_new <= -PIPE_W_S);

`ifdef PIPES_SCROLLER_SCORE_EN
    localparam logic signed [11:0] BIRD_X_S = 12'(BIRD_X);
    logic signed [11:0] edge_old, edge_new;

    assign edge_old    = x_old + PIPE_W_S;
    assign edge_new    = x_new + PIPE_W_S;
    assign score_pulse = in_pass && (edge_old > BIRD_X_S) && (edge_new <= BIRD_X_S);
`else
    localparam int UNUSED_BIRD_X = BIRD_X;
    assign score_pulse = 1'b0;
`endif

    assign spawn_next = spawn_cnt_q - SPEED_S;

    always_comb begin
        state_d       = state_q;
        spawn_cnt_d   = spawn_cnt_q;
        overrun_d     = overrun_q;
        iter_start_d  = 1'b0;
        insert_en_d   = 1'b0;
        insert_data_d = insert_data_q;
        lfsr_step     = 1'b0;

        if (frame_tick && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    lfsr_step    = 1'b1;
                    iter_start_d = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: state_d = S_FIRST;
            S_FIRST, S_ITER: state_d = iter_done ? S_SPAWN : S_ITER;
            S_SPAWN: begin
                state_d = S_IDLE;
                if (spawn_next <= 12'sd0) begin
                    insert_en_d         = 1'b1;
                    insert_data_d.x     = SPAWN_X;
                    insert_data_d.gap_y = GAP_MIN_9 + {1'b0, lfsr_value[7:0]};
                    spawn_cnt_d         = SPAWN_DIST_S;
                end else begin
                    spawn_cnt_d = spawn_next;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            spawn_cnt_q   <= '0;
            overrun_q     <= 1'b0;
            iter_start_q  <= 1'b0;
            insert_en_q   <= 1'b0;
            insert_data_q <= '0;
            busy_q        <= 1'b0;
        end else if (ce) begin
            state_q       <= state_d;
            spawn_cnt_q   <= spawn_cnt_d;
            overrun_q     <= overrun_d;
            iter_start_q  <= iter_start_d;
            insert_en_q   <= insert_en_d;
            insert_data_q <= insert_data_d;
            busy_q        <= busy_d;
        end
    end

    assign iter_start  = iter_start_q;
    assign insert_en   = insert_en_q;
    assign insert_data = insert_data_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule
